// File: rtl/move_ctrl_pkg.sv
// Shared display constants, direction bit indices and FSM encoding for move_ctrl.
// The clamp helper keeps the 11-bit signed next position inside the visible object range.
package move_ctrl_pkg;

    localparam int unsigned H_VIS_DEF = 640;
    localparam int unsigned V_VIS_DEF = 480;

    localparam int unsigned POS_W  = 10;
    localparam int unsigned CALC_W = 11;

    // Bit positions inside the {u,d,l,r} direction vector
    localparam int unsigned DIR_R = 0;
    localparam int unsigned DIR_L = 1;
    localparam int unsigned DIR_D = 2;
    localparam int unsigned DIR_U = 3;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    function automatic logic [POS_W-1:0] clamp_axis(
        input logic signed [CALC_W-1:0] v,
        input logic signed [CALC_W-1:0] hi
    );
        logic [POS_W-1:0] res;
        if (v < 0) begin
            res = '0;
        end else if (v > hi) begin
            res = hi[POS_W-1:0];
        end else begin
            res = v[POS_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/move_ctrl_btn_debounce.sv
// Button input path: 2-FF synchronizer followed by a stable-count debouncer.
// The level flips only after DEB_CYCLES consecutive disagreeing samples; any bounce restarts.
module move_ctrl_btn_debounce #(
    parameter int unsigned DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/move_ctrl.sv
// Per-frame motion controller: debounced buttons move a clamped object once per vertical blank.
// A held direction accelerates the step; positions only change in the WAIT->CALC->COMMIT pass.
module move_ctrl
    import move_ctrl_pkg::*;
#(
    parameter int unsigned H_VIS        = H_VIS_DEF,
    parameter int unsigned V_VIS        = V_VIS_DEF,
    parameter int unsigned OBJ_SIZE     = 16,
    parameter int unsigned DEB_CYCLES   = 500000,
    parameter int unsigned STEP_MIN     = 1,
    parameter int unsigned STEP_MAX     = 4,
    parameter int unsigned ACCEL_FRAMES = 8,
    parameter int unsigned X_INIT       = 312,
    parameter int unsigned Y_INIT       = 232
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             u,
    input  logic             d,
    input  logic             l,
    input  logic             r,
    input  logic [POS_W-1:0] pix_x,
    input  logic [POS_W-1:0] pix_y,
    output logic [POS_W-1:0] obj_x,
    output logic [POS_W-1:0] obj_y,
    output logic             frame_tick,
    output logic             moving
);

    localparam int unsigned STEP_W = $clog2(STEP_MAX + 1);
    localparam int unsigned CNT_W  = $clog2(ACCEL_FRAMES + 1);
    localparam logic signed [CALC_W-1:0] X_MAX = CALC_W'(H_VIS - OBJ_SIZE);
    localparam logic signed [CALC_W-1:0] Y_MAX = CALC_W'(V_VIS - OBJ_SIZE);

    logic [3:0] btn_raw, dir_deb;

    assign btn_raw = {u, d, l, r};

    for (genvar i = 0; i < 4; i++) begin : g_deb
        move_ctrl_btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .btn  (btn_raw[i]),
            .level(dir_deb[i])
        );
    end

    // Reset release is synchronized so the FSM never starts on a partial deassertion
    logic [1:0] rst_sync_q;
    logic       cmp, cmp_q, frame_tick_q;

    assign cmp = (pix_y == POS_W'(V_VIS)) && (pix_x == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q   <= '0;
            cmp_q        <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            rst_sync_q   <= {rst_sync_q[0], 1'b1};
            cmp_q        <= cmp;
            frame_tick_q <= cmp && !cmp_q;
        end
    end

    assign frame_tick = frame_tick_q;

    state_e             state_q, state_d;
    logic [3:0]         dir_q, dir_d, prev_dir_q, prev_dir_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [POS_W-1:0]   nx_q, nx_d, ny_q, ny_d;
    logic [POS_W-1:0]   obj_x_q, obj_x_d, obj_y_q, obj_y_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_WAIT;
            dir_q       <= '0;
            prev_dir_q  <= '0;
            step_q      <= STEP_W'(STEP_MIN);
            frame_cnt_q <= '0;
            nx_q        <= POS_W'(X_INIT);
            ny_q        <= POS_W'(Y_INIT);
            obj_x_q     <= POS_W'(X_INIT);
            obj_y_q     <= POS_W'(Y_INIT);
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            prev_dir_q  <= prev_dir_d;
            step_q      <= step_d;
            frame_cnt_q <= frame_cnt_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            obj_x_q     <= obj_x_d;
            obj_y_q     <= obj_y_d;
        end
    end

    assign obj_x = obj_x_q;
    assign obj_y = obj_y_q;

    logic signed [CALC_W-1:0] step_s, x_cur, y_cur, x_sum, y_sum;

    always_comb begin
        step_s = $signed({{(CALC_W - STEP_W){1'b0}}, step_q});
        x_cur  = $signed({1'b0, obj_x_q});
        y_cur  = $signed({1'b0, obj_y_q});
        x_sum  = x_cur;
        y_sum  = y_cur;
        if (dir_q[DIR_R] && !dir_q[DIR_L]) begin
            x_sum = x_cur + step_s;
        end else if (dir_q[DIR_L] && !dir_q[DIR_R]) begin
            x_sum = x_cur - step_s;
        end
        if (dir_q[DIR_D] && !dir_q[DIR_U]) begin
            y_sum = y_cur + step_s;
        end else if (dir_q[DIR_U] && !dir_q[DIR_D]) begin
            y_sum = y_cur - step_s;
        end
    end

    // A fresh direction counts as the first frame of its run
    logic              same_dir;
    logic [STEP_W-1:0] base_step, acc_step;
    logic [CNT_W-1:0]  run_cnt, acc_cnt;

    always_comb begin
        same_dir  = (dir_q == prev_dir_q);
        base_step = same_dir ? step_q : STEP_W'(STEP_MIN);
        run_cnt   = same_dir ? frame_cnt_q + 1'b1 : CNT_W'(1);
        acc_step  = base_step;
        acc_cnt   = run_cnt;
        if (dir_q == '0) begin
            acc_step = STEP_W'(STEP_MIN);
            acc_cnt  = '0;
        end else if (run_cnt >= CNT_W'(ACCEL_FRAMES)) begin
            acc_cnt = '0;
            if (base_step < STEP_W'(STEP_MAX)) begin
                acc_step = base_step + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        prev_dir_d  = prev_dir_q;
        step_d      = step_q;
        frame_cnt_d = frame_cnt_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        obj_x_d     = obj_x_q;
        obj_y_d     = obj_y_q;
        moving      = 1'b0;
        unique case (state_q)
            ST_WAIT: begin
                if (frame_tick_q && rst_sync_q[1]) begin
                    state_d = ST_CALC;
                    dir_d   = dir_deb;
                end
            end
            ST_CALC: begin
                nx_d        = clamp_axis(x_sum, X_MAX);
                ny_d        = clamp_axis(y_sum, Y_MAX);
                step_d      = acc_step;
                frame_cnt_d = acc_cnt;
                prev_dir_d  = dir_q;
                state_d     = ST_COMMIT;
            end
            ST_COMMIT: begin
                obj_x_d = nx_q;
                obj_y_d = ny_q;
                moving  = (nx_q != obj_x_q) || (ny_q != obj_y_q);
                state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

endmodule
